// File: rtl/mantissa_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : mantissa_normalizer
// Brief    : Post-add normalization; shifts the mantissa left one bit per
//            cycle until the hidden bit is set, decrementing the exponent.
// Revision : 1.0 - initial release
// ============================================================================
module mantissa_normalizer #(
    parameter int ExponentSize = 8,
    parameter int MantissaSize = 24
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic                    InSign,
    input  logic [ExponentSize-1:0] InExponent,
    input  logic [MantissaSize-1:0] InMantissa,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic                    OutSign,
    output logic [ExponentSize-1:0] OutExponent,
    output logic [MantissaSize-1:0] OutMantissa,
    output logic                    Zero,
    output logic                    Underflow
);

    localparam logic [1:0] c_STATE_IDLE  = 2'd0;
    localparam logic [1:0] c_STATE_SHIFT = 2'd1;
    localparam logic [1:0] c_STATE_DONE  = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_nextState;
    logic [ExponentSize-1:0] r_workExp;
    logic [MantissaSize-1:0] r_workMant;
    logic                    r_workSign;
    logic                    r_outSign;
    logic [ExponentSize-1:0] r_outExp;
    logic [MantissaSize-1:0] r_outMant;
    logic                    r_zero;
    logic                    r_underflow;

    logic w_mantIsZero;
    logic w_hiddenSet;
    logic w_expIsZero;

    assign w_mantIsZero = (r_workMant == '0);
    assign w_hiddenSet  = r_workMant[MantissaSize-1];
    assign w_expIsZero  = (r_workExp == '0);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_STATE_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_STATE_IDLE: begin
                if (InValid) begin
                    w_nextState = c_STATE_SHIFT;
                end
            end
            c_STATE_SHIFT: begin
                if (w_mantIsZero || w_hiddenSet || w_expIsZero) begin
                    w_nextState = c_STATE_DONE;
                end
            end
            c_STATE_DONE: begin
                if (OutReady) begin
                    w_nextState = c_STATE_IDLE;
                end
            end
            default: w_nextState = c_STATE_IDLE;
        endcase
    end

    // Output logic; ready is also masked by Reset so no operand is offered
    // acceptance while the block is being cleared.
    always_comb begin
        InReady  = 1'b0;
        OutValid = 1'b0;
        case (r_state)
            c_STATE_IDLE: InReady  = ~Reset;
            c_STATE_DONE: OutValid = 1'b1;
            default: begin
                InReady  = 1'b0;
                OutValid = 1'b0;
            end
        endcase
    end

    // Datapath: working registers plus a separate result bank that only
    // updates on the decision edge, so outputs hold steady outside DONE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_workExp   <= '0;
            r_workMant  <= '0;
            r_workSign  <= 1'b0;
            r_outSign   <= 1'b0;
            r_outExp    <= '0;
            r_outMant   <= '0;
            r_zero      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (r_state)
                c_STATE_IDLE: begin
                    if (InValid) begin
                        r_workExp   <= InExponent;
                        r_workMant  <= InMantissa;
                        r_workSign  <= InSign;
                        r_zero      <= 1'b0;
                        r_underflow <= 1'b0;
                    end
                end
                c_STATE_SHIFT: begin
                    if (w_mantIsZero) begin
                        r_workExp  <= '0;
                        r_workSign <= 1'b0;
                        r_outExp   <= '0;
                        r_outMant  <= '0;
                        r_outSign  <= 1'b0;
                        r_zero     <= 1'b1;
                    end else if (w_hiddenSet) begin
                        r_outExp  <= r_workExp;
                        r_outMant <= r_workMant;
                        r_outSign <= r_workSign;
                    end else if (w_expIsZero) begin
                        r_outExp    <= r_workExp;
                        r_outMant   <= r_workMant;
                        r_outSign   <= r_workSign;
                        r_underflow <= 1'b1;
                    end else begin
                        r_workMant <= {r_workMant[MantissaSize-2:0], 1'b0};
                        r_workExp  <= r_workExp - ExponentSize'(1);
                    end
                end
                default: begin
                    r_workExp <= r_workExp;
                end
            endcase
        end
    end

    assign OutSign     = r_outSign;
    assign OutExponent = r_outExp;
    assign OutMantissa = r_outMant;
    assign Zero        = r_zero;
    assign Underflow   = r_underflow;

endmodule
`default_nettype wire
